// File: rtl/cache_request_controller.sv
// cache_request_controller
//   Front-end sequencer for the 2-way, 4-set cache. Arbitrates two requesters
//   round-robin, issues one 9-bit cache instruction at a time, samples the
//   cache result, stalls for the writeback/refill penalty on a miss, and then
//   acknowledges the winning requester. Keeps saturating hit/miss/writeback
//   statistics.
//
// Ports
//   clock, reset_n            : clock; synchronous active-low reset
//   req0/req1, instr0/instr1  : requests and their {wr, index, tag, data} words
//   ack0/ack1                 : one-cycle completion pulses
//   rdata, resp_miss          : result of the acked request (valid with ack)
//   cache_req                 : one-cycle strobe qualifying cache_instruction
//   cache_instruction         : latched instruction of the granted requester
//   cache_miss/wback/data     : cache results, valid the cycle after cache_req
//   busy, mem_busy            : not-IDLE / in WRITEBACK or FILL
//   hit_count/miss_count/wb_count : saturating statistics
module cache_request_controller #(
   parameter int WB_CYCLES   = 4,
   parameter int FILL_CYCLES = 4,
   parameter int CNT_W       = 8
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             req0,
   input  logic             req1,
   input  logic [8:0]       instr0,
   input  logic [8:0]       instr1,
   output logic             ack0,
   output logic             ack1,
   output logic [2:0]       rdata,
   output logic             resp_miss,
   output logic             cache_req,
   output logic [8:0]       cache_instruction,
   input  logic             cache_miss,
   input  logic             cache_wback,
   input  logic [2:0]       cache_data,
   output logic             busy,
   output logic             mem_busy,
   output logic [CNT_W-1:0] hit_count,
   output logic [CNT_W-1:0] miss_count,
   output logic [CNT_W-1:0] wb_count
);

   localparam int MAX_CYC = (WB_CYCLES > FILL_CYCLES) ? WB_CYCLES : FILL_CYCLES;
   localparam int DW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_CHECK,
      S_WRITEBACK,
      S_FILL,
      S_RESPOND
   } state_t;

   state_t          state;
   state_t          state_next;
   logic [DW-1:0]   delay_cnt;
   logic            grant_id;
   logic            last_grant;
   logic            pick;
   logic [8:0]      instr_q;
   logic [2:0]      data_q;
   logic            miss_q;

   // The cache's wback output is stale on hit paths, so it only matters
   // together with a miss.
   logic dirty_miss;
   assign dirty_miss = cache_miss & cache_wback;

   // NOTE: every signal written here gets a default first so no latch is inferred.
   always_comb begin
      state_next = state;
      pick       = req1;
      if (req0 && req1) begin
         pick = ~last_grant;
      end
      case (state)
         S_IDLE:      if (req0 || req1) state_next = S_ISSUE;
         S_ISSUE:     state_next = S_CHECK;
         S_CHECK: begin
            if (dirty_miss)      state_next = S_WRITEBACK;
            else if (cache_miss) state_next = S_FILL;
            else                 state_next = S_RESPOND;
         end
         S_WRITEBACK: if (delay_cnt == '0) state_next = S_FILL;
         S_FILL:      if (delay_cnt == '0) state_next = S_RESPOND;
         S_RESPOND:   state_next = S_IDLE;
         default:     state_next = S_IDLE;
      endcase
   end

   assign cache_req         = (state == S_ISSUE);
   assign cache_instruction = instr_q;
   assign busy              = (state != S_IDLE);
   assign mem_busy          = (state == S_WRITEBACK) || (state == S_FILL);
   assign ack0              = (state == S_RESPOND) && !grant_id;
   assign ack1              = (state == S_RESPOND) && grant_id;
   assign rdata             = data_q;
   assign resp_miss         = miss_q && (state == S_RESPOND);

   // NOTE: sequential state uses non-blocking assignments so every register
   // sees the pre-edge values of the others.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state      <= S_IDLE;
         delay_cnt  <= '0;
         grant_id   <= 1'b0;
         last_grant <= 1'b1;
         instr_q    <= 9'b0;
         data_q     <= 3'b000;
         miss_q     <= 1'b0;
         hit_count  <= '0;
         miss_count <= '0;
         wb_count   <= '0;
      end else begin
         state <= state_next;
         case (state)
            S_IDLE: begin
               if (req0 || req1) begin
                  grant_id   <= pick;
                  last_grant <= pick;
                  instr_q    <= pick ? instr1 : instr0;
               end
            end
            S_CHECK: begin
               data_q <= cache_data;
               miss_q <= cache_miss;
               // Preload the first penalty phase; WRITEBACK reloads for FILL.
               delay_cnt <= dirty_miss ? DW'(WB_CYCLES - 1) : DW'(FILL_CYCLES - 1);
               if (!cache_miss && hit_count != '1)  hit_count  <= hit_count + 1'b1;
               if (cache_miss && miss_count != '1)  miss_count <= miss_count + 1'b1;
               if (dirty_miss && wb_count != '1)    wb_count   <= wb_count + 1'b1;
            end
            S_WRITEBACK: begin
               if (delay_cnt == '0) delay_cnt <= DW'(FILL_CYCLES - 1);
               else                 delay_cnt <= delay_cnt - 1'b1;
            end
            S_FILL: begin
               if (delay_cnt != '0) delay_cnt <= delay_cnt - 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_cache_request_controller.sv
// Directed testbench for cache_request_controller. A small responder stands
// in for the cache: in the cycle after cache_req it returns the per-test
// miss/wback/data values, and drives inverted junk in every other cycle.
// A second instance with CNT_W=2 shares all inputs to observe saturation.
module tb_cache_request_controller;

   logic       clock = 1'b0;
   logic       reset_n, req0, req1;
   logic [8:0] instr0, instr1;
   logic       cache_miss, cache_wback;
   logic [2:0] cache_data;

   logic       ack0, ack1, resp_miss, cache_req, busy, mem_busy;
   logic [2:0] rdata;
   logic [8:0] cache_instruction;
   logic [7:0] hit_count, miss_count, wb_count;

   logic       s_ack0, s_ack1, s_resp_miss, s_cache_req, s_busy, s_mem_busy;
   logic [2:0] s_rdata;
   logic [8:0] s_cache_instruction;
   logic [1:0] s_hit_count, s_miss_count, s_wb_count;

   int tests_run    = 0;
   int tests_failed = 0;

   logic       rsp_miss, rsp_wb;
   logic [2:0] rsp_data;

   always #5 clock = ~clock;

   cache_request_controller u_dut (
      .clock(clock), .reset_n(reset_n), .req0(req0), .req1(req1),
      .instr0(instr0), .instr1(instr1), .ack0(ack0), .ack1(ack1),
      .rdata(rdata), .resp_miss(resp_miss), .cache_req(cache_req),
      .cache_instruction(cache_instruction), .cache_miss(cache_miss),
      .cache_wback(cache_wback), .cache_data(cache_data), .busy(busy),
      .mem_busy(mem_busy), .hit_count(hit_count), .miss_count(miss_count),
      .wb_count(wb_count)
   );

   cache_request_controller #(.CNT_W(2)) u_sat (
      .clock(clock), .reset_n(reset_n), .req0(req0), .req1(req1),
      .instr0(instr0), .instr1(instr1), .ack0(s_ack0), .ack1(s_ack1),
      .rdata(s_rdata), .resp_miss(s_resp_miss), .cache_req(s_cache_req),
      .cache_instruction(s_cache_instruction), .cache_miss(cache_miss),
      .cache_wback(cache_wback), .cache_data(cache_data), .busy(s_busy),
      .mem_busy(s_mem_busy), .hit_count(s_hit_count), .miss_count(s_miss_count),
      .wb_count(s_wb_count)
   );

   // Cache stand-in: results valid only in the cycle after cache_req.
   always @(posedge clock) begin
      if (cache_req) begin
         cache_miss  <= rsp_miss;
         cache_wback <= rsp_wb;
         cache_data  <= rsp_data;
      end else begin
         cache_miss  <= ~rsp_miss;
         cache_wback <= ~rsp_wb;
         cache_data  <= ~rsp_data;
      end
   end

   // Protocol watch: cache_req never twice in a row, acks never together.
   logic creq_prev = 1'b0;
   int   creq_double = 0;
   int   dual_ack = 0;
   always @(posedge clock) begin
      if (cache_req && creq_prev) creq_double++;
      creq_prev = cache_req;
      if (ack0 && ack1) dual_ack++;
   end

   task automatic apply_reset();
      @(negedge clock);
      reset_n = 1'b0;
      req0 = 1'b0;
      req1 = 1'b0;
      repeat (2) @(negedge clock);
      reset_n = 1'b1;
   endtask

   // Raises one request in cycle 0 and records what happens until its ack.
   task automatic run_req(input bit id, input logic [8:0] ins,
                          output int ack_cyc, output int creq_cyc,
                          output int mb_first, output int mb_last,
                          output logic [2:0] rd, output logic rm,
                          output logic [8:0] ci, output int wrong_ack);
      ack_cyc = -1; creq_cyc = -1; mb_first = -1; mb_last = -1;
      rd = 3'b000; rm = 1'b0; ci = 9'b0; wrong_ack = 0;
      @(negedge clock);
      if (id) begin req1 = 1'b1; instr1 = ins; end
      else    begin req0 = 1'b1; instr0 = ins; end
      for (int c = 1; c <= 40 && ack_cyc < 0; c++) begin
         @(posedge clock);
         #1;
         if (cache_req && creq_cyc < 0) begin creq_cyc = c; ci = cache_instruction; end
         if (mem_busy) begin
            if (mb_first < 0) mb_first = c;
            mb_last = c;
         end
         if (id ? ack0 : ack1) wrong_ack++;
         if (id ? ack1 : ack0) begin
            ack_cyc = c; rd = rdata; rm = resp_miss;
         end
      end
      req0 = 1'b0;
      req1 = 1'b0;
      @(negedge clock);
   endtask

   task automatic test_reset();
      reset_n = 1'b0; req0 = 1'b0; req1 = 1'b0;
      instr0 = 9'b0; instr1 = 9'b0;
      rsp_miss = 1'b0; rsp_wb = 1'b0; rsp_data = 3'b000;
      repeat (3) @(posedge clock);
      #1;
      tests_run++;
      if ({ack0, ack1, cache_req, busy, mem_busy, resp_miss} !== 6'b0) begin
         tests_failed++;
         $display("FAIL reset_ctrl: got %b expected 000000",
                  {ack0, ack1, cache_req, busy, mem_busy, resp_miss});
      end
      tests_run++;
      if ({hit_count, miss_count, wb_count} !== 24'h0) begin
         tests_failed++;
         $display("FAIL reset_counters: got %h expected 000000", {hit_count, miss_count, wb_count});
      end
      tests_run++;
      if ({rdata, cache_instruction} !== 12'h0) begin
         tests_failed++;
         $display("FAIL reset_data: got rdata=%b instr=%b expected 0", rdata, cache_instruction);
      end
      @(negedge clock);
      reset_n = 1'b1;
   endtask

   task automatic test_read_hit();
      int a, cr, mf, ml, wa; logic [2:0] rd; logic rm; logic [8:0] ci;
      // wback is driven high on purpose: it must be ignored on a hit.
      rsp_miss = 1'b0; rsp_wb = 1'b1; rsp_data = 3'b011;
      run_req(1'b0, 9'b0_01_000_000, a, cr, mf, ml, rd, rm, ci, wa);
      tests_run++;
      if (cr !== 1 || ci !== 9'b0_01_000_000) begin
         tests_failed++;
         $display("FAIL hit_issue: got cycle %0d instr %b expected cycle 1 instr 001000000", cr, ci);
      end
      tests_run++;
      if (a !== 3 || wa !== 0 || mf !== -1) begin
         tests_failed++;
         $display("FAIL hit_ack: got cycle %0d wrong_acks %0d mem_busy_at %0d expected 3/0/-1", a, wa, mf);
      end
      tests_run++;
      if (rd !== 3'b011 || rm !== 1'b0) begin
         tests_failed++;
         $display("FAIL hit_result: got rdata=%b miss=%b expected 011/0", rd, rm);
      end
      tests_run++;
      if (hit_count !== 8'd1 || miss_count !== 8'd0 || wb_count !== 8'd0) begin
         tests_failed++;
         $display("FAIL hit_counts: got h=%0d m=%0d w=%0d expected 1/0/0", hit_count, miss_count, wb_count);
      end
   endtask

   task automatic test_clean_miss();
      int a, cr, mf, ml, wa; logic [2:0] rd; logic rm; logic [8:0] ci;
      rsp_miss = 1'b1; rsp_wb = 1'b0; rsp_data = 3'b110;
      run_req(1'b1, 9'b0_00_000_000, a, cr, mf, ml, rd, rm, ci, wa);
      tests_run++;
      if (mf !== 3 || ml !== 6) begin
         tests_failed++;
         $display("FAIL clean_mem_busy: got cycles %0d..%0d expected 3..6", mf, ml);
      end
      tests_run++;
      if (a !== 7 || wa !== 0 || rm !== 1'b1) begin
         tests_failed++;
         $display("FAIL clean_ack: got cycle %0d wrong_acks %0d miss=%b expected 7/0/1", a, wa, rm);
      end
      tests_run++;
      if (hit_count !== 8'd1 || miss_count !== 8'd1 || wb_count !== 8'd0) begin
         tests_failed++;
         $display("FAIL clean_counts: got h=%0d m=%0d w=%0d expected 1/1/0", hit_count, miss_count, wb_count);
      end
   endtask

   task automatic test_dirty_miss();
      int a, cr, mf, ml, wa; logic [2:0] rd; logic rm; logic [8:0] ci;
      rsp_miss = 1'b1; rsp_wb = 1'b1; rsp_data = 3'b101;
      run_req(1'b0, 9'b0_10_000_000, a, cr, mf, ml, rd, rm, ci, wa);
      tests_run++;
      if (mf !== 3 || ml !== 10) begin
         tests_failed++;
         $display("FAIL dirty_mem_busy: got cycles %0d..%0d expected 3..10", mf, ml);
      end
      tests_run++;
      if (a !== 11 || wa !== 0 || rm !== 1'b1 || rd !== 3'b101) begin
         tests_failed++;
         $display("FAIL dirty_ack: got cycle %0d wrong %0d miss=%b rdata=%b expected 11/0/1/101", a, wa, rm, rd);
      end
      tests_run++;
      if (hit_count !== 8'd1 || miss_count !== 8'd2 || wb_count !== 8'd1) begin
         tests_failed++;
         $display("FAIL dirty_counts: got h=%0d m=%0d w=%0d expected 1/2/1", hit_count, miss_count, wb_count);
      end
   endtask

   // Both requesters raise together and hold until their own ack.
   task automatic tie_round(input string tag);
      int who [2];
      int when [2];
      int n = 0;
      who[0] = -1; who[1] = -1; when[0] = -1; when[1] = -1;
      @(negedge clock);
      req0 = 1'b1; instr0 = 9'b0_01_000_000;
      req1 = 1'b1; instr1 = 9'b0_11_001_010;
      for (int c = 1; c <= 40 && n < 2; c++) begin
         @(posedge clock);
         #1;
         if (ack0) begin who[n] = 0; when[n] = c; n++; req0 = 1'b0; end
         else if (ack1) begin who[n] = 1; when[n] = c; n++; req1 = 1'b0; end
      end
      req0 = 1'b0; req1 = 1'b0;
      @(negedge clock);
      tests_run++;
      if (who[0] !== 0 || when[0] !== 3) begin
         tests_failed++;
         $display("FAIL %s_first: got requester %0d at cycle %0d expected 0 at 3", tag, who[0], when[0]);
      end
      tests_run++;
      if (who[1] !== 1 || when[1] !== 7) begin
         tests_failed++;
         $display("FAIL %s_second: got requester %0d at cycle %0d expected 1 at 7", tag, who[1], when[1]);
      end
   endtask

   task automatic test_tie_arbitration();
      apply_reset();
      rsp_miss = 1'b0; rsp_wb = 1'b0; rsp_data = 3'b011;
      tie_round("tie1");
      tie_round("tie2");
      tests_run++;
      if (hit_count !== 8'd4) begin
         tests_failed++;
         $display("FAIL tie_hits: got %0d expected 4", hit_count);
      end
   endtask

   task automatic test_reset_mid_fill();
      int acks = 0;
      logic mb5;
      rsp_miss = 1'b1; rsp_wb = 1'b0; rsp_data = 3'b111;
      @(negedge clock);
      req0 = 1'b1; instr0 = 9'b0_00_000_000;
      for (int c = 1; c <= 5; c++) begin
         @(posedge clock);
         #1;
         if (ack0 || ack1) acks++;
      end
      mb5 = mem_busy;
      reset_n = 1'b0;
      req0 = 1'b0;
      @(posedge clock);
      #1;
      tests_run++;
      if (mb5 !== 1'b1) begin
         tests_failed++;
         $display("FAIL rst_fill_entry: got mem_busy=%b at 3rd FILL cycle expected 1", mb5);
      end
      tests_run++;
      if (busy !== 1'b0 || mem_busy !== 1'b0 || ack0 !== 1'b0 || ack1 !== 1'b0) begin
         tests_failed++;
         $display("FAIL rst_fill_state: got busy=%b mem_busy=%b acks=%b%b expected 0/0/00",
                  busy, mem_busy, ack0, ack1);
      end
      tests_run++;
      if ({hit_count, miss_count, wb_count} !== 24'h0) begin
         tests_failed++;
         $display("FAIL rst_fill_counters: got %h expected 000000", {hit_count, miss_count, wb_count});
      end
      @(negedge clock);
      reset_n = 1'b1;
      repeat (20) begin
         @(posedge clock);
         #1;
         if (ack0 || ack1) acks++;
      end
      tests_run++;
      if (acks !== 0) begin
         tests_failed++;
         $display("FAIL rst_fill_no_ack: got %0d acks expected 0", acks);
      end
   endtask

   task automatic test_saturation();
      int a, cr, mf, ml, wa; logic [2:0] rd; logic rm; logic [8:0] ci;
      logic [1:0] exp_sat;
      apply_reset();
      rsp_miss = 1'b0; rsp_wb = 1'b0; rsp_data = 3'b011;
      for (int n = 1; n <= 5; n++) begin
         run_req(1'b0, 9'b0_01_000_000, a, cr, mf, ml, rd, rm, ci, wa);
         exp_sat = (n > 3) ? 2'd3 : 2'(n);
         tests_run++;
         if (s_hit_count !== exp_sat || hit_count !== 8'(n) || a !== 3) begin
            tests_failed++;
            $display("FAIL sat_hit_%0d: got sat=%0d wide=%0d ack=%0d expected %0d/%0d/3",
                     n, s_hit_count, hit_count, a, exp_sat, n);
         end
      end
      tests_run++;
      if (s_miss_count !== 2'd0 || s_wb_count !== 2'd0) begin
         tests_failed++;
         $display("FAIL sat_others: got m=%0d w=%0d expected 0/0", s_miss_count, s_wb_count);
      end
   endtask

   task automatic test_protocol();
      tests_run++;
      if (creq_double !== 0 || dual_ack !== 0) begin
         tests_failed++;
         $display("FAIL protocol: got back-to-back cache_req %0d, dual acks %0d expected 0/0",
                  creq_double, dual_ack);
      end
   endtask

   initial begin
      test_reset();
      test_read_hit();
      test_clean_miss();
      test_dirty_miss();
      test_tie_arbitration();
      test_reset_mid_fill();
      test_saturation();
      test_protocol();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/cache_request_controller.md
# cache_request_controller

Front-end sequencer for the 2-way, 4-set cache block. Arbitrates two requesters (round-robin), issues one 9-bit cache instruction at a time, and samples the cache's `miss`/`wback`/`data_out` results. On a miss it stalls the winning requester for a fixed memory-penalty sequence (optional writeback, then refill) before acknowledging, and keeps hit/miss/writeback statistics.

## Interface
- `WB_CYCLES`, default 4: writeback penalty in cycles; must be ≥1.
- `FILL_CYCLES`, default 4: refill penalty in cycles; must be ≥1.
- `CNT_W`, default 8: statistics counter width.
- `clock` in 1: single clock; all state updates on its rising edge.
- `reset_n` in 1: synchronous, active-low reset.
- `req0`, `req1` in 1: request from requester 0 / 1; held high until the matching ack.
- `instr0`, `instr1` in 9: instruction `{wr, index[1:0], tag[2:0], data[2:0]}`; stable while req is high.
- `ack0`, `ack1` out 1: one-cycle completion pulse to requester 0 / 1.
- `rdata` out 3: cache `data_out` captured for the acked request; valid only while an ack is high.
- `resp_miss` out 1: the acked request missed; valid only while an ack is high.
- `cache_req` out 1: one-cycle strobe; the cache consumes `cache_instruction` only when this is 1.
- `cache_instruction` out 9: latched instruction of the granted requester.
- `cache_miss`, `cache_wback` in 1; `cache_data` in 3: cache results, valid the cycle after `cache_req`.
- `busy` out 1: high in every state except IDLE.
- `mem_busy` out 1: high during WRITEBACK and FILL.
- `hit_count`, `miss_count`, `wb_count` out CNT_W: saturating statistics.

## Operation
- States are IDLE, ISSUE, CHECK, WRITEBACK, FILL and RESPOND.
- **IDLE:**
  - Neither req high → stay.
  - One req high → grant it.
  - Both high → grant the requester not granted last. The last-grant pointer resets to 1, so requester 0 wins the first tie.
  - On a grant: latch the instruction and grant id, update the pointer, go to ISSUE.
- **ISSUE:** `cache_req`=1 and `cache_instruction`=latched value for exactly one cycle → CHECK.
- **CHECK:** capture `cache_data` and `cache_miss`. `cache_wback` counts only when `cache_miss`=1, because the cache's `wback` holds its previous value on paths that don't assign it.
  - miss & wback → WRITEBACK.
  - miss & !wback → FILL.
  - !miss → RESPOND.
- **WRITEBACK:** down-counter loaded with WB_CYCLES-1; stay exactly WB_CYCLES cycles → FILL.
- **FILL:** counter loaded with FILL_CYCLES-1; stay exactly FILL_CYCLES cycles → RESPOND.
- **RESPOND:**
  - Pulse ack of the granted id.
  - Drive `rdata` from the captured data and `resp_miss` from the captured miss.
  - Go to IDLE.
  - For writes, `rdata` is don't-care.
- **Counters** update in CHECK; each saturates at all-ones and never wraps.
  - `hit_count` +1 if !miss.
  - `miss_count` +1 if miss.
  - `wb_count` +1 if miss & wback.
- **Reset** (reset_n=0 at an edge), in any state including mid-WRITEBACK/FILL:
  - state → IDLE; the in-flight request is dropped with no ack.
  - Outputs go to their reset values (below); last-grant pointer → 1.
  - The cache array itself is not reset.

## Timing
- Cycle 0 is the IDLE cycle in which the request is sampled.
  - Hit: ISSUE at 1, CHECK at 2, ack at cycle 3.
  - Clean miss: ack at cycle 3+FILL_CYCLES.
  - Dirty miss: ack at cycle 3+WB_CYCLES+FILL_CYCLES.
- Ack at cycle t → IDLE at t+1 samples requests again. A req still high at t+1 is a new request, so back-to-back requests are legal; requesters drop req at t+1 if they have nothing further.
- At most one request is outstanding. A non-granted req waits; no requester can be starved for more than one service.
- `cache_req` is never high in two consecutive cycles.
- A req rising mid-service is not seen until IDLE.
- Reset values:
  - Outputs at 0: `ack0`, `ack1`, `cache_req`, `busy`, `mem_busy`, `resp_miss`, all three counters.
  - `rdata` = 3'b000; `cache_instruction` = 9'b0.

## Test plan
Run with the cache's power-up contents and default parameters, in this order (the order sets the cache's `wback` register).
1. **Read hit:** reset, then `req0`, `instr0`=9'b0_01_000_000 → `cache_req` at cycle 1; `ack0` at cycle 3 with `rdata`=3'b011, `resp_miss`=0; `hit_count`=1.
2. **Clean miss:** `req1`, `instr1`=9'b0_00_000_000 (both ways invalid) → `mem_busy` for cycles 3–6; `ack1` at cycle 7 with `resp_miss`=1; `miss_count`=1, `wb_count`=0.
3. **Dirty miss:** `req0`, `instr0`=9'b0_10_000_000 (evicts dirty way 0) → `mem_busy` for cycles 3–10; `ack0` at cycle 11 with `resp_miss`=1, `rdata`=3'b101; `wb_count`=1.
4. **Tie arbitration:** after reset, raise `req0` and `req1` together with read-hit instructions, held until each is acked → `ack0` first, then `ack1` on the next service; on a second tie, `ack0` is served again.
5. **Reset mid-operation:** assert `reset_n`=0 during the 3rd FILL cycle → next cycle `busy`=0, `mem_busy`=0, all counters 0, no ack ever issued for that request.
6. **Counter saturation:** with CNT_W=2, issue 5 hits → `hit_count` reads 3 and holds.
